// File: rtl/fstack_cached_if.sv
// rtl/fstack_cached_if.sv - operation and status bundle for the cached Forth stack
interface fstack_cached_if #(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH)
);
    logic           en;
    logic [2:0]     op;
    logic [DSZ-1:0] vi;
    logic [SSZ-1:0] idx;
    logic [DSZ-1:0] tos;
    logic [DSZ-1:0] nos;
    logic [SSZ:0]   depth;
    logic           empty;
    logic           full;
    logic           err_ovf;
    logic           err_udf;

    modport master (
        output en, op, vi, idx,
        input  tos, nos, depth, empty, full, err_ovf, err_udf
    );

    modport slave (
        input  en, op, vi, idx,
        output tos, nos, depth, empty, full, err_ovf, err_udf
    );
endinterface

// File: rtl/fstack_cached.sv
// rtl/fstack_cached.sv - Forth stack with TOS/NOS in registers and the rest in a flop array
module fstack_cached #(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic            clk,
    input  logic            rst,
    fstack_cached_if.slave  bus
);
    localparam int SSZ = $clog2(DEPTH);
    localparam int MD  = DEPTH - 2;
    localparam int MW  = $clog2(MD);

    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_REPL = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_PICK = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;

    localparam logic [SSZ:0] D_ZERO = '0;
    localparam logic [SSZ:0] D_ONE  = (SSZ+1)'(1);
    localparam logic [SSZ:0] D_TWO  = (SSZ+1)'(2);
    localparam logic [SSZ:0] D_TRI  = (SSZ+1)'(3);
    localparam logic [SSZ:0] D_FULL = (SSZ+1)'(DEPTH);

    logic [DSZ-1:0] r_tos, r_nos;
    logic [SSZ:0]   r_depth;
    logic           r_ovf, r_udf;
    logic [DSZ-1:0] r_mem [MD];

    logic [DSZ-1:0] w_tos_n, w_nos_n, w_pick_val;
    logic [SSZ:0]   w_depth_n, w_wr_full, w_rd_full, w_pk_full;
    logic           w_ovf_n, w_udf_n, w_mem_we;
    logic           w_empty, w_full;
    logic [MW-1:0]  w_wr_addr, w_rd_addr, w_pk_addr;

    assign w_empty = (r_depth == D_ZERO);
    assign w_full  = (r_depth == D_FULL);

    // Element k>=2 sits at mem[depth-1-k], so the array grows upward from slot 0.
    assign w_wr_full = r_depth - D_TWO;
    assign w_rd_full = r_depth - D_TRI;
    assign w_pk_full = r_depth - D_ONE - {1'b0, bus.idx};
    assign w_wr_addr = w_wr_full[MW-1:0];
    assign w_rd_addr = w_rd_full[MW-1:0];
    assign w_pk_addr = w_pk_full[MW-1:0];

    always_comb begin
        w_pick_val = r_mem[w_pk_addr];
        if (bus.idx == '0)
            w_pick_val = r_tos;
        else if (bus.idx == SSZ'(1))
            w_pick_val = r_nos;
    end

    always_comb begin
        w_tos_n   = r_tos;
        w_nos_n   = r_nos;
        w_depth_n = r_depth;
        w_ovf_n   = r_ovf;
        w_udf_n   = r_udf;
        w_mem_we  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OP_PUSH, OP_PICK: begin
                    if (w_full) begin
                        w_ovf_n = 1'b1;
                    end else if (bus.op == OP_PICK && {1'b0, bus.idx} >= r_depth) begin
                        w_udf_n = 1'b1;
                    end else begin
                        w_mem_we  = (r_depth >= D_TWO);
                        w_nos_n   = r_tos;
                        w_tos_n   = (bus.op == OP_PICK) ? w_pick_val : bus.vi;
                        w_depth_n = r_depth + D_ONE;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        w_udf_n = 1'b1;
                    end else begin
                        // NOS is already 0 below depth 2, so popping the last cell clears TOS.
                        w_tos_n   = r_nos;
                        w_nos_n   = (r_depth >= D_TRI) ? r_mem[w_rd_addr] : '0;
                        w_depth_n = r_depth - D_ONE;
                    end
                end
                OP_REPL: begin
                    if (w_empty) w_udf_n = 1'b1;
                    else         w_tos_n = bus.vi;
                end
                OP_SWAP: begin
                    if (r_depth < D_TWO) begin
                        w_udf_n = 1'b1;
                    end else begin
                        w_tos_n = r_nos;
                        w_nos_n = r_tos;
                    end
                end
                OP_CLR: begin
                    w_tos_n   = '0;
                    w_nos_n   = '0;
                    w_depth_n = '0;
                    w_ovf_n   = 1'b0;
                    w_udf_n   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos   <= '0;
            r_nos   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_tos   <= w_tos_n;
            r_nos   <= w_nos_n;
            r_depth <= w_depth_n;
            r_ovf   <= w_ovf_n;
            r_udf   <= w_udf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_mem_we)
            r_mem[w_wr_addr] <= r_nos;
    end

    assign bus.tos     = r_tos;
    assign bus.nos     = r_nos;
    assign bus.depth   = r_depth;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.err_ovf = r_ovf;
    assign bus.err_udf = r_udf;
endmodule
